// File: rtl/stream_unpacker.sv
// Wide-to-narrow stream converter: one RATIO-lane word in, RATIO beats out, lane 0 first.
// Optional out_last port is enabled by defining STREAM_UNPACKER_LAST_EN.
module stream_unpacker #(
    parameter int DATA_WIDTH = 32,
    parameter int RATIO      = 4
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [DATA_WIDTH*RATIO-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready
`ifdef STREAM_UNPACKER_LAST_EN
    ,
    output logic                        out_last
`endif
);

    localparam int            CW       = $clog2(RATIO);
    localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

    logic [RATIO-1:0][DATA_WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic                             full_q, full_d;
    logic                             last_lane;
    logic                             in_xfer;
    logic                             out_xfer;

    assign last_lane = (cnt_q == CNT_LAST);
    // Accept the next word on the same edge the final lane leaves, so there is no bubble.
    assign in_ready  = ~full_q | (out_ready & last_lane);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = full_q & out_ready;
    assign out_valid = full_q;
    assign out_data  = word_q[cnt_q];

`ifdef STREAM_UNPACKER_LAST_EN
    assign out_last  = full_q & last_lane;
`endif

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (out_xfer) begin
            if (last_lane) begin
                full_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + CW'(1);
            end
        end
        if (in_xfer) begin
            word_d = in_data;
            cnt_d  = '0;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            word_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

endmodule
